// File: rtl/aes_buf_pkg.sv
// -----------------------------------------------------------------------------
// aes_buf_pkg
// Shared constants and helpers for the AES block buffer.
//   DEF_BYTE_W / DEF_BYTES / DEF_BANKS : default geometry (one 128-bit AES
//                                        block per bank, double buffered)
//   AES_BLOCK_BYTES                    : bytes in an AES state / round key
//   ptr_inc_wrap()                     : bank pointer increment, wraps
//                                        BANKS-1 -> 0 for any bank count
// -----------------------------------------------------------------------------
package aes_buf_pkg;

  localparam int unsigned AES_BLOCK_BYTES = 16;
  localparam int unsigned DEF_BYTE_W      = 8;
  localparam int unsigned DEF_BYTES       = AES_BLOCK_BYTES;
  localparam int unsigned DEF_BANKS       = 2;

  // Bank counts need not be powers of two, so wrap explicitly.
  function automatic int unsigned ptr_inc_wrap(input int unsigned ptr,
                                               input int unsigned banks);
    return (ptr >= banks - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/aes_buf_bank.sv
// -----------------------------------------------------------------------------
// aes_buf_bank
// One BYTES x BYTE_W register bank.
//   clk        : clock, all updates on rising edge
//   rst_ni     : synchronous active-low reset, zeroes every byte
//   wr_en_i    : write wr_data_i into byte wr_addr_i
//   wr_addr_i  : byte address
//   wr_data_i  : byte value
//   clr_i      : synchronous clear of the whole bank (wins over a write)
//   data_o     : flat bank contents, byte 0 in the MSBs
// -----------------------------------------------------------------------------
module aes_buf_bank
  import aes_buf_pkg::*;
#(
  parameter  int unsigned BYTE_W = DEF_BYTE_W,
  parameter  int unsigned BYTES  = DEF_BYTES,
  localparam int unsigned AW     = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic                    wr_en_i,
  input  logic [AW-1:0]           wr_addr_i,
  input  logic [BYTE_W-1:0]       wr_data_i,
  input  logic                    clr_i,
  output logic [BYTES*BYTE_W-1:0] data_o
);

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte
    logic [BYTE_W-1:0] byte_q;

    always_ff @(posedge clk) begin
      if (!rst_ni || clr_i) begin
        byte_q <= '0;
      end else if (wr_en_i && (wr_addr_i == AW'(gi))) begin
        byte_q <= wr_data_i;
      end
    end

    assign data_o[(BYTES-1-gi)*BYTE_W +: BYTE_W] = byte_q;
  end

endmodule

// File: rtl/aes_block_buffer.sv
// -----------------------------------------------------------------------------
// aes_block_buffer
// Multi-bank byte buffer for AES state / round-key blocks. Bytes are written
// at random addresses into the current write bank, read back combinationally,
// then the bank is committed as a block. Committed blocks leave in FIFO order
// on a valid/ready interface while the next bank is being loaded.
//
// Optional feature macro: AES_BUF_FILL_TRACK_EN
//   defined   : per-byte written mask for the write bank; commit is only
//               accepted once every byte has been written (fill_done)
//   undefined : no mask, fill_done tied high
//
// Ports:
//   clk        : clock
//   rst        : synchronous active-low reset
//   wr_en      : write wr_data to wr_addr of the write bank
//   wr_addr    : write byte address
//   wr_data    : write byte
//   rd_addr    : readback byte address
//   rd_data    : write-bank byte at rd_addr (0 when no write bank available)
//   commit     : close write bank as a complete block
//   wr_ready   : a write bank is available (level < BANKS)
//   blk_valid  : at least one committed block queued
//   blk_ready  : consumer accepts blk_data
//   blk_data   : oldest committed block, byte 0 in MSBs (0 when empty)
//   level      : committed blocks queued
//   fill_done  : every byte of the write bank written since last commit
//   overflow   : sticky, wr_en/commit seen while it could not be accepted
// -----------------------------------------------------------------------------
module aes_block_buffer
  import aes_buf_pkg::*;
#(
  parameter  int unsigned BYTE_W = DEF_BYTE_W,
  parameter  int unsigned BYTES  = DEF_BYTES,
  parameter  int unsigned BANKS  = DEF_BANKS,
  localparam int unsigned AW     = (BYTES > 1) ? $clog2(BYTES) : 1,
  localparam int unsigned LW     = $clog2(BANKS + 1),
  localparam int unsigned PW     = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [BYTE_W-1:0]       wr_data,
  input  logic [AW-1:0]           rd_addr,
  output logic [BYTE_W-1:0]       rd_data,
  input  logic                    commit,
  output logic                    wr_ready,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic [BYTES*BYTE_W-1:0] blk_data,
  output logic [LW-1:0]           level,
  output logic                    fill_done,
  output logic                    overflow
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;

  logic fill_ok;
  logic wr_acc;
  logic commit_acc;
  logic pop;

  logic [BYTES*BYTE_W-1:0] bank_data [BANKS];

  assign wr_ready   = (level_q != LW'(BANKS));
  assign blk_valid  = (level_q != '0);
  assign wr_acc     = wr_en && wr_ready;
  assign commit_acc = commit && wr_ready && fill_ok;
  assign pop        = blk_valid && blk_ready;

  assign level      = level_q;
  assign overflow   = overflow_q;

`ifdef AES_BUF_FILL_TRACK_EN
  logic [BYTES-1:0] mask_q, mask_d;

  // The mask follows the write bank: an accepted commit hands out a fresh
  // (all-zero) bank, so it restarts empty even if a write lands that cycle.
  always_comb begin
    mask_d = mask_q;
    if (commit_acc) begin
      mask_d = '0;
    end else if (wr_acc) begin
      mask_d[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign fill_done = &mask_q;
  assign fill_ok   = fill_done;
`else
  assign fill_done = 1'b1;
  assign fill_ok   = 1'b1;
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    // A commit that is not accepted (full or bank incomplete) is an overflow.
    overflow_d = overflow_q | (wr_en && !wr_ready) | (commit && !commit_acc);

    if (commit_acc) begin
      wr_ptr_d = PW'(ptr_inc_wrap(32'(wr_ptr_q), BANKS));
    end
    if (pop) begin
      rd_ptr_d = PW'(ptr_inc_wrap(32'(rd_ptr_q), BANKS));
    end

    case ({commit_acc, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Write and pop never target the same bank: when level is 0 there is no
  // pop, when full there is no write, otherwise wr_ptr != rd_ptr.
  for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
    aes_buf_bank #(
      .BYTE_W (BYTE_W),
      .BYTES  (BYTES)
    ) u_bank (
      .clk       (clk),
      .rst_ni    (rst),
      .wr_en_i   (wr_acc && (wr_ptr_q == PW'(gi))),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .clr_i     (pop && (rd_ptr_q == PW'(gi))),
      .data_o    (bank_data[gi])
    );
  end

  always_comb begin
    rd_data  = '0;
    blk_data = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (wr_ready && (wr_ptr_q == PW'(b))) begin
        for (int i = 0; i < BYTES; i++) begin
          if (rd_addr == AW'(i)) begin
            rd_data = bank_data[b][(BYTES-1-i)*BYTE_W +: BYTE_W];
          end
        end
      end
      if (blk_valid && (rd_ptr_q == PW'(b))) begin
        blk_data = bank_data[b];
      end
    end
  end

endmodule

// File: tb/tb_aes_block_buffer.sv
// -----------------------------------------------------------------------------
// tb_aes_block_buffer
// Self-checking bench for aes_block_buffer with default geometry (8-bit bytes,
// 16 bytes, 2 banks). A behavioural model keeps the write-bank contents, level
// and overflow; committed blocks are pushed to a scoreboard queue and compared
// against blk_data while queued and when popped. Fill tracking checks are
// compiled in when AES_BUF_FILL_TRACK_EN is defined.
// -----------------------------------------------------------------------------
module tb_aes_block_buffer;

  localparam int BYTE_W = 8;
  localparam int BYTES  = 16;
  localparam int BANKS  = 2;

  logic                    clk;
  logic                    rst;
  logic                    wr_en;
  logic [3:0]              wr_addr;
  logic [BYTE_W-1:0]       wr_data;
  logic [3:0]              rd_addr;
  logic [BYTE_W-1:0]       rd_data;
  logic                    commit;
  logic                    wr_ready;
  logic                    blk_valid;
  logic                    blk_ready;
  logic [BYTES*BYTE_W-1:0] blk_data;
  logic [1:0]              level;
  logic                    fill_done;
  logic                    overflow;

  aes_block_buffer #(
    .BYTE_W (BYTE_W),
    .BYTES  (BYTES),
    .BANKS  (BANKS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .commit    (commit),
    .wr_ready  (wr_ready),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .level     (level),
    .fill_done (fill_done),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [7:0]   m_bank [BYTES];
  int           m_level;
  bit           m_ovf;
  bit [15:0]    m_mask;
  logic [127:0] exp_q [$];

  task automatic check_val(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] flat_bank();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < BYTES; i++) f[(BYTES-1-i)*8 +: 8] = m_bank[i];
    return f;
  endfunction

  function automatic bit exp_fill_done();
`ifdef AES_BUF_FILL_TRACK_EN
    return &m_mask;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BYTES; i++) m_bank[i] = 8'h00;
    m_level = 0;
    m_ovf   = 1'b0;
    m_mask  = '0;
    exp_q.delete();
  endtask

  task automatic check_state();
    check_val("level",     level,     m_level);
    check_val("wr_ready",  wr_ready,  m_level != BANKS);
    check_val("blk_valid", blk_valid, m_level != 0);
    check_val("overflow",  overflow,  m_ovf);
    check_val("fill_done", fill_done, exp_fill_done());
  endtask

  task automatic set_idle();
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    commit    = 1'b0;
    blk_ready = 1'b0;
  endtask

  // Hold rst low across one edge, then every output must be at its reset value.
  task automatic do_reset();
    set_idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_val("rst_rd_data",  rd_data,  '0);
    check_val("rst_blk_data", blk_data, '0);
    check_state();
    rst = 1'b1;
  endtask

  // One clock of stimulus. Combinational outputs are compared before the edge,
  // the model is advanced, then registered state is compared after the edge.
  task automatic do_cycle(input bit we, input int addr, input logic [7:0] d,
                          input bit cm, input bit rdy, input int ra);
    bit rdy_w, fill_ok, pop;
    wr_en     = we;
    wr_addr   = 4'(addr);
    wr_data   = d;
    commit    = cm;
    blk_ready = rdy;
    rd_addr   = 4'(ra);
    #1;
    rdy_w = (m_level != BANKS);
    check_val("rd_data", rd_data, rdy_w ? m_bank[ra] : 8'h00);
    check_val("blk_data", blk_data, (m_level != 0) ? exp_q[0] : 128'h0);

    pop     = (m_level != 0) && rdy;
    fill_ok = exp_fill_done();
    if (we) begin
      if (rdy_w) begin
        m_bank[addr] = d;
        m_mask[addr] = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (cm) begin
      if (rdy_w && fill_ok) begin
        exp_q.push_back(flat_bank());
        for (int i = 0; i < BYTES; i++) m_bank[i] = 8'h00;
        m_mask = '0;
        m_level++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (pop) begin
      void'(exp_q.pop_front());
      m_level--;
    end

    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic write_block();
    for (int i = 0; i < BYTES; i++)
      do_cycle(1'b1, i, 8'($urandom_range(0, 255)), 1'b0, 1'b0, i);
  endtask

  initial begin
    rst     = 1'b0;
    rd_addr = '0;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Sequential bytes, readback, commit.
    for (int i = 0; i < BYTES; i++) do_cycle(1'b1, i, 8'(i), 1'b0, 1'b0, 5);
    check_val("readback5", rd_data, 8'h05);
    do_cycle(1'b0, 0, 8'h00, 1'b1, 1'b0, 0);
    check_val("blk0_const", blk_data, 128'h000102030405060708090a0b0c0d0e0f);

    // Fill the second bank, then a commit while full must be refused.
    write_block();
    do_cycle(1'b0, 0, 8'h00, 1'b1, 1'b0, 0);
    do_cycle(1'b1, 2, 8'h55, 1'b1, 1'b0, 2);
    do_cycle(1'b0, 0, 8'h00, 1'b0, 1'b1, 0);

    // Commit and pop together keeps level; reused bank reads back zero.
    write_block();
    do_cycle(1'b0, 0, 8'h00, 1'b1, 1'b1, 0);
    for (int i = 0; i < BYTES; i++) do_cycle(1'b0, 0, 8'h00, 1'b0, 1'b0, i);

    // Write landing in the same cycle as commit belongs to the committed block.
    write_block();
    do_cycle(1'b1, 3, 8'hAB, 1'b1, 1'b0, 3);
    do_cycle(1'b0, 0, 8'h00, 1'b0, 1'b1, 0);
    check_val("byte3", blk_data[(BYTES-1-3)*8 +: 8], 8'hAB);
    do_cycle(1'b0, 0, 8'h00, 1'b0, 1'b1, 0);
    do_cycle(1'b0, 0, 8'h00, 1'b0, 1'b0, 0);

`ifdef AES_BUF_FILL_TRACK_EN
    // Incomplete bank: commit refused until the last byte arrives.
    do_reset();
    for (int i = 0; i < BYTES - 1; i++)
      do_cycle(1'b1, i, 8'(8'hC0 + i), 1'b0, 1'b0, i);
    do_cycle(1'b0, 0, 8'h00, 1'b1, 1'b0, 0);
    check_val("fill_partial", fill_done, 1'b0);
    do_cycle(1'b1, BYTES - 1, 8'hEE, 1'b0, 1'b0, 0);
    check_val("fill_full", fill_done, 1'b1);
    do_cycle(1'b0, 0, 8'h00, 1'b1, 1'b0, 0);
    do_cycle(1'b0, 0, 8'h00, 1'b0, 1'b1, 0);
`endif

    // Reset in the middle of a block with one block queued.
    do_reset();
    write_block();
    do_cycle(1'b0, 0, 8'h00, 1'b1, 1'b0, 0);
    do_cycle(1'b1, 1, 8'h77, 1'b0, 1'b0, 1);
    do_cycle(1'b1, 2, 8'h88, 1'b0, 1'b0, 1);
    rd_addr = 4'd1;
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_block_buffer.md
# aes_block_buffer

Parametrised, multi-bank byte buffer for AES state/round-key blocks. A producer (key expansion or round datapath) writes bytes at random addresses into the current write bank, reads them back combinationally, then commits the bank as a complete block. Committed blocks queue in FIFO order and leave on a valid/ready block interface, so the next block loads while the previous one is consumed.

## Interface
Parameters:
- BYTE_W, 8, bits per byte lane
- BYTES, 16, byte lanes per block (128-bit AES block)
- BANKS, 2, number of block banks (≥2, any integer)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous and active-low
- wr_en  input  1  write byte wr_data to wr_addr of write bank
- wr_addr  input  $clog2(BYTES)  byte address for write
- wr_data  input  BYTE_W  byte to write
- rd_addr  input  $clog2(BYTES)  byte address for readback
- rd_data  output  BYTE_W  write-bank byte at rd_addr (combinational)
- commit  input  1  close write bank as a complete block
- wr_ready  output  1  write bank available (level < BANKS)
- blk_valid  output  1  at least one committed block queued
- blk_ready  input  1  consumer accepts blk_data
- blk_data  output  BYTES*BYTE_W  oldest committed block; byte 0 in MSBs
- level  output  $clog2(BANKS+1)  number of committed blocks queued
- fill_done  output  1  every byte of write bank written since last commit
- overflow  output  1  sticky: wr_en or commit seen while wr_ready=0

## Operation
- State: BANKS register banks, wr_ptr, rd_ptr (wrap BANKS-1 → 0), level, overflow, per-byte written mask.
- Write: wr_en && wr_ready → bank[wr_ptr][wr_addr] ← wr_data. wr_en while !wr_ready dropped, overflow set.
- Readback: rd_data = bank[wr_ptr][rd_addr] when wr_ready, else 0.
- Commit accepted when commit && wr_ready (and fill condition, see Configuration): wr_ptr++, level++. Same-cycle wr_en lands in the bank being committed.
- Pop when blk_valid && blk_ready: popped bank zeroed, rd_ptr++, level--. New write banks therefore always start all-zero.
- Accepted commit and pop together: both pointers advance, level unchanged.
- When full (level = BANKS): commit ignored, overflow set; a same-cycle pop still occurs.
- blk_valid = (level != 0); blk_data = bank[rd_ptr] when valid, else 0.
- overflow clears only on reset.
- Reset (any cycle, incl. mid-block): all banks zero, pointers 0, level 0, mask 0, overflow 0.

## Timing
- Reset values: rd_data 0, wr_ready 1, blk_valid 0, blk_data 0, level 0, fill_done 0 (1 without macro), overflow 0.
- Write → rd_data updated the cycle after the edge (zero-cycle combinational read of registered data).
- Commit → blk_valid high 1 cycle later; one block per cycle throughput.
- blk_data stable while blk_valid && !blk_ready.
- Pop at full → wr_ready high next cycle.

## Configuration
- AES_BUF_FILL_TRACK_EN defined: per-byte written mask tracked for write bank; fill_done = &mask; commit accepted only if fill_done, otherwise ignored and overflow set; mask cleared on accepted commit and on reset.
- Undefined: no mask logic; fill_done tied 1; commit accepted whenever wr_ready.

## Structure
- Package aes_buf_pkg: default BYTE_W/BYTES/BANKS constants, AES_BLOCK_BYTES = 16, pointer-increment-with-wrap function.
- Sub-module aes_buf_bank: one BYTES×BYTE_W register bank with byte write, synchronous clear, flat MSB-first output; instantiated BANKS times.

## Test plan
- Reset, write bytes 0x00..0x0F to addr 0..15, commit → next cycle blk_valid=1, blk_data=0x000102…0F, level=1; readback of addr 5 before commit = 0x05.
- Hold blk_ready=0, commit two blocks (BANKS=2) → wr_ready=0, level=2; third commit → ignored, overflow=1; pop → first block out, wr_ready=1.
- Commit + pop same cycle with level=1 → level stays 1, blk_data switches to newer block; popped bank reads back all 0 when reused.
- Write addr 3 = 0xAB in same cycle as commit → committed block byte 3 = 0xAB.
- With AES_BUF_FILL_TRACK_EN: write 15 of 16 bytes, commit → ignored, overflow=1, fill_done=0; write last byte → fill_done=1, commit accepted.
- Assert rst=0 mid-block with level=1 → next cycle all outputs at reset values, blk_data=0.
